// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: FSM encoding and shared constants for the APB register slave.
package apb_slv_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10
    } state_e;
    localparam logic [31:0] ID_VALUE_DEF = 32'hA5B0_0001;
    localparam int CNT_W = 4;
endpackage

// File: rtl/apb_slv_regbank.sv
// apb_slv_regbank: register storage with read-only ID at index 0 and a combinational read mux.
module apb_slv_regbank #(
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic                        hclk,
    input  logic                        hresetn,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] widx,
    input  logic [31:0]                 wdata,
    input  logic [$clog2(NUM_REGS)-1:0] ridx,
    output logic [31:0]                 rdata
);
    logic [31:0] regs [NUM_REGS];
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && widx != '0) begin
            regs[widx] <= wdata;
        end
    end
    assign rdata = (ridx == '0) ? ID_VALUE : regs[ridx];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 register endpoint with registered outputs and error decode.
// Define APB_SLV_WAIT_EN to add the WAIT state and honour WAIT_CYCLES.
module apb_slave_regfile
    import apb_slv_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEF
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        wr_pulse
);
    localparam int AW = $clog2(NUM_REGS);
    state_e      state, state_n;
    logic [31:0] addr_q, wdata_q, addr_s, rdata;
    logic        wr_q, wr_s, err_s, setup, we;
`ifdef APB_SLV_WAIT_EN
    logic [CNT_W-1:0] cnt, cnt_n;
`endif
    // In IDLE the decode looks at the bus so a zero-wait access can answer one edge after setup
    assign setup  = psel && !penable;
    assign addr_s = (state == ST_IDLE) ? paddr : addr_q;
    assign wr_s   = (state == ST_IDLE) ? pwrite : wr_q;
    assign err_s  = (addr_s[1:0] != 2'b00) || (addr_s[31:2] >= 30'(NUM_REGS)) || (wr_s && addr_s[31:2] == 30'd0);
    assign we     = (state == ST_ACCESS) && psel && wr_q && !err_s;
    apb_slv_regbank #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) u_bank (
        .hclk(hclk), .hresetn(hresetn), .we(we), .widx(addr_q[AW+1:2]),
        .wdata(wdata_q), .ridx(addr_s[AW+1:2]), .rdata(rdata)
    );
    always_comb begin
        state_n = state;
`ifdef APB_SLV_WAIT_EN
        cnt_n = cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (setup) begin
`ifdef APB_SLV_WAIT_EN
                    state_n = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                    cnt_n   = CNT_W'(WAIT_CYCLES);
`else
                    state_n = ST_ACCESS;
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            ST_WAIT: begin
                state_n = !psel ? ST_IDLE : (cnt == CNT_W'(1)) ? ST_ACCESS : ST_WAIT;
                cnt_n   = psel ? cnt - CNT_W'(1) : '0;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            wr_pulse <= 1'b0;
`ifdef APB_SLV_WAIT_EN
            cnt      <= '0;
`endif
        end else begin
            state <= state_n;
            if (state == ST_IDLE && setup) begin
                addr_q  <= paddr;
                wr_q    <= pwrite;
                wdata_q <= pwdata;
            end
            pready   <= state_n == ST_ACCESS;
            pslverr  <= state_n == ST_ACCESS && err_s;
            prdata   <= (state_n == ST_ACCESS && !wr_s && !err_s) ? rdata : '0;
            wr_pulse <= we;
`ifdef APB_SLV_WAIT_EN
            cnt      <= cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: random and directed APB traffic checked against an array model.
module tb_apb_slave_regfile;
    localparam int          NUM_REGS    = 8;
    localparam int          WAIT_CYCLES = 3;
    localparam logic [31:0] ID          = 32'hA5B0_0001;
`ifdef APB_SLV_WAIT_EN
    localparam int LAT = WAIT_CYCLES;
`else
    localparam int LAT = 0;
`endif
    logic        hclk = 1'b0, hresetn = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, wr_pulse;
    logic [31:0] model [NUM_REGS];
    int          tests = 0, errors = 0;

    apb_slave_regfile #(.NUM_REGS(NUM_REGS), .WAIT_CYCLES(WAIT_CYCLES), .ID_VALUE(ID)) dut (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .wr_pulse(wr_pulse)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
        int          idx, k;
        logic        err;
        logic [31:0] exp_rd;
        idx    = int'(a >> 2);
        err    = (a[1:0] != 2'b00) || (idx >= NUM_REGS) || (w && idx == 0);
        exp_rd = (w || err) ? 32'd0 : (idx == 0) ? ID : model[idx];
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge hclk); #1;
        penable = 1'b1;
        k = 0;
        while (!pready && k < 40) begin
            @(posedge hclk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'(LAT));
        chk("pslverr", 32'(pslverr), 32'(err));
        chk("prdata", prdata, exp_rd);
        chk("wr_pulse_early", 32'(wr_pulse), 32'd0);
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b0;
        chk("pready_drop", 32'(pready), 32'd0);
        chk("wr_pulse", 32'(wr_pulse), 32'(w && !err));
        if (w && !err) model[idx] = d;
    endtask

    task automatic abort_wr(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge hclk); #1;
        penable = 1'b1;
        if (LAT > 1) begin
            @(posedge hclk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        repeat (2) begin
            @(posedge hclk); #1;
            chk("abort_wr_pulse", 32'(wr_pulse), 32'd0);
            chk("abort_pready", 32'(pready), 32'd0);
        end
    endtask

    task automatic reset_mid(input logic [31:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge hclk); #1;
        penable = 1'b1;
        if (LAT > 0) begin
            @(posedge hclk); #1;
        end
        #2 hresetn = 1'b0;
        #2;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge hclk); #2;
        hresetn = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        @(posedge hclk); #1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        #2 hresetn = 1'b0;
        #5;
        chk("reset_prdata", prdata, 32'd0);
        chk("reset_pready", 32'(pready), 32'd0);
        chk("reset_pslverr", 32'(pslverr), 32'd0);
        chk("reset_wr_pulse", 32'(wr_pulse), 32'd0);
        #10 hresetn = 1'b1;
        @(posedge hclk); #1;
        xfer(32'h08, 1'b1, 32'hDEAD_BEEF);
        xfer(32'h08, 1'b0, 32'h0);
        xfer(32'h00, 1'b0, 32'h0);
        xfer(32'h00, 1'b1, 32'h1234_5678);
        xfer(32'h00, 1'b0, 32'h0);
        xfer(32'h20, 1'b0, 32'h0);
        xfer(32'h06, 1'b0, 32'h0);
        xfer(32'h1C, 1'b1, 32'hCAFE_F00D);
        xfer(32'h1C, 1'b0, 32'h0);
        abort_wr(32'h04, 32'h5555_AAAA);
        xfer(32'h04, 1'b0, 32'h0);
        xfer(32'h04, 1'b1, 32'h0BAD_F00D);
        reset_mid(32'h04, 32'h7777_7777);
        xfer(32'h04, 1'b0, 32'h0);
        xfer(32'h08, 1'b0, 32'h0);
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 9)) << 2;
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            xfer(a, 1'($urandom_range(0, 1)), $urandom);
        end
        for (int i = 0; i < NUM_REGS; i++) xfer(32'(i) << 2, 1'b0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB3 responder that terminates one select line (one bit of `pselx`) from the AHB-to-APB bridge controller and exposes a bank of 32-bit control/status registers. It samples the APB setup phase and inserts a programmable number of wait states. It then completes the access with `pready`. It flags illegal accesses with `pslverr`. It runs in the bridge's clock domain, and any peripheral behind the bridge can instantiate it as a ready-made register endpoint.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers, power of two, 2..64.
- `WAIT_CYCLES`, 2: wait states inserted before `pready`, 0..15. Only honoured with `APB_SLV_WAIT_EN`.
- `ID_VALUE`, 32'hA5B0_0001: read-only contents of register 0.
- `hclk` input 1: the single clock, rising-edge.
- `hresetn` input 1: reset, asynchronous and active-low.
- `psel` input 1: this slave's select bit (one bit of the bridge's `pselx`).
- `penable` input 1: APB access-phase indicator.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input 32: byte address. Bits [1:0] must be 0.
- `pwdata` input 32: write data.
- `prdata` output 32: read data. Valid only while `pready`=1 on a read, else 0.
- `pready` output 1: access-phase completion.
- `pslverr` output 1: error response. Valid only while `pready`=1, else 0.
- `wr_pulse` output 1: one-cycle strobe after every successful register write.

## Operation
- FSM states: IDLE, WAIT, ACCESS. Reset state is IDLE.
- IDLE:
  - When `psel`=1 and `penable`=0 are sampled, latch `paddr`, `pwrite`, `pwdata`.
  - Go to WAIT and load counter = `WAIT_CYCLES` if `WAIT_CYCLES`>0, else go to ACCESS.
  - `psel`=1 with `penable`=1 in IDLE (no setup phase) is ignored.
- WAIT: counter decrements each cycle. Go to ACCESS when the counter reaches 1.
- ACCESS:
  - `pready`=1 for exactly one cycle. The transfer completes at the following edge; return to IDLE.
- Error decode, from the latched values. Any of these sets `pslverr`=1 in ACCESS:
  - `paddr[1:0]`≠0.
  - `paddr[31:2]` ≥ `NUM_REGS`.
  - A write to register 0.
- Error accesses change no register, and `wr_pulse` stays 0.
- Write: register index = `paddr[2+log2(NUM_REGS)-1:2]`. The register updates at the completion edge. `wr_pulse`=1 in the following cycle.
- Read: `prdata` = register contents during ACCESS. Register 0 reads `ID_VALUE`. Error reads return 0.
- Abort: `psel` falls while in WAIT or ACCESS. Return to IDLE at the next edge, with no register update and no `wr_pulse`.
- Back-to-back transfers: a setup phase sampled in the first IDLE cycle after completion is accepted normally.

## Timing
- All outputs are registered.
- Reset values: `prdata`=0, `pready`=0, `pslverr`=0, `wr_pulse`=0, registers 1..N-1 = 0, FSM = IDLE, counter = 0.
- Reset takes effect immediately, including mid-transfer. Any pending write is discarded.
- Setup phase sampled at edge T0 → `pready` high in cycle T0+`WAIT_CYCLES`…+1.
  - `WAIT_CYCLES`=0 gives a zero-wait APB access: completion at T1.
  - `WAIT_CYCLES`=N gives completion at T(N+1).
- The register value is visible to a read whose setup phase starts in the cycle after completion.

## Configuration
- `APB_SLV_WAIT_EN` defined: the WAIT state and the 4-bit counter exist, and `WAIT_CYCLES` is honoured.
- `APB_SLV_WAIT_EN` undefined:
  - The WAIT state and counter are removed, and `WAIT_CYCLES` is ignored.
  - IDLE always goes straight to ACCESS, so every transfer completes one edge after setup.

## Structure
- Package `apb_slv_pkg` holds:
  - the FSM state encoding (IDLE=2'b00, WAIT=2'b01, ACCESS=2'b10);
  - the default `ID_VALUE`;
  - the width constant of the wait counter.
- Sub-module `apb_slv_regbank` holds the register storage, the write-enable decode, the register-0 read-only logic and the read mux.
- The top level holds the FSM, the wait counter, the error decode and the output registers.

## Test plan
- Zero-wait write, then read:
  - Setup: `paddr`=0x08, `pwdata`=0xDEAD_BEEF, `WAIT_CYCLES`=0.
  - Required: `pready` at T1 and `pslverr`=0, `wr_pulse` at T2, then a read of 0x08 returns 0xDEAD_BEEF.
- Waited read of the ID register with `WAIT_CYCLES`=3:
  - Required: `pready` low for 3 access cycles, then `prdata`=0xA5B0_0001 with `pready`=1 at T4.
- Errors:
  - Write to 0x00 → `pslverr`=1, register 0 unchanged.
  - Read of 0x20 with `NUM_REGS`=8 → `pslverr`=1, `prdata`=0.
  - Read of 0x06 → `pslverr`=1.
- Abort: drop `psel` during WAIT of a write to 0x04 → FSM returns to IDLE, register 1 stays 0, no `wr_pulse`.
- Reset: assert `hresetn` asynchronously mid-WAIT → `pready`=0 and register 1 reads 0 after release.
- Build with `APB_SLV_WAIT_EN` undefined and `WAIT_CYCLES`=5 → every access completes at T1.
